onchip_mem_reader: RTL and testbench

- Avalon-MM read master that streams a contiguous byte region out of the 8-bit single-port on-chip sample RAM.
- The RAM is a slave with a fixed 1-cycle read latency and no waitrequest.
- Output is a valid/ready byte stream with a last flag; the display/readout path consumes it when dumping a captured trace.
- Absorbs downstream backpressure with a 2-entry output buffer; sustains 1 byte/clk when out_ready is held high.

---
 rtl/onchip_mem_reader_if.sv | 31 +++
 rtl/onchip_mem_reader.sv | 118 +++++++++++
 tb/tb_onchip_mem_reader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_reader_if.sv
// Bus bundle for onchip_mem_reader: Avalon-MM read port toward the sample RAM
// and the valid/ready byte stream toward the readout path.
interface onchip_mem_reader_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_chipselect;
  logic                  avm_write;
  logic [DATA_WIDTH-1:0] avm_writedata;
  logic                  avm_clken;
  logic [DATA_WIDTH-1:0] avm_readdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_writedata, avm_clken,
    input  avm_readdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_writedata, avm_clken,
    output avm_readdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/onchip_mem_reader.sv
// Streams a contiguous region of the on-chip sample RAM out as a byte stream,
// issuing reads only when the 2-entry output buffer can absorb the return.
module onchip_mem_reader #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  onchip_mem_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic [LEN_WIDTH-1:0]  rx_cnt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            fifo_count;
  logic [1:0]            occupancy;
  logic                  push;
  logic                  pop;
  logic                  room;
  logic                  issue;

  assign push      = inflight;
  assign pop       = bus.out_valid & bus.out_ready;
  assign tail      = head ^ fifo_count[0];
  // An in-flight read already owns a slot, so it counts against the buffer.
  assign occupancy = fifo_count + {1'b0, inflight};
  assign room      = (occupancy - {1'b0, pop}) < 2'd2;

  assign bus.avm_address    = addr;
  assign bus.avm_chipselect = issue;
  assign bus.avm_write      = 1'b0;
  assign bus.avm_writedata  = '0;
  assign bus.avm_clken      = 1'b1;
  assign bus.out_valid      = (fifo_count != 2'd0);
  assign bus.out_data       = fifo_data[head];
  assign bus.out_last       = bus.out_valid & fifo_last[head];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = (length == '0) ? FINISH : READ;
      READ:   if (issue && issue_cnt == LEN_WIDTH'(1)) state_next = DRAIN;
      DRAIN:  if (pop && bus.out_last) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    case (state)
      READ: begin
        busy  = 1'b1;
        issue = (issue_cnt != '0) && room;
      end
      DRAIN:  busy = 1'b1;
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr       <= '0;
      issue_cnt  <= '0;
      rx_cnt     <= '0;
      inflight   <= 1'b0;
      head       <= 1'b0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (state == IDLE && start) begin
        addr      <= base_addr;
        issue_cnt <= length;
        rx_cnt    <= length;
      end
      if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        issue_cnt <= issue_cnt - LEN_WIDTH'(1);
      end
      inflight <= issue;
      // With count==2 a push only happens alongside a pop, and tail then
      // aliases the slot being vacated.
      if (push) begin
        fifo_data[tail] <= bus.avm_readdata;
        fifo_last[tail] <= (rx_cnt == LEN_WIDTH'(1));
        rx_cnt          <= rx_cnt - LEN_WIDTH'(1);
      end
      if (pop) head <= ~head;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_onchip_mem_reader.sv
// Directed bench for onchip_mem_reader with a 1-cycle-latency RAM model and
// an independent model of when a read may be issued.
module tb_onchip_mem_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;

  onchip_mem_reader_if #(.ADDR_WIDTH(15), .DATA_WIDTH(8)) bus ();

  onchip_mem_reader #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:32767];
  logic [7:0] rdata;
  always @(posedge clk) if (bus.avm_chipselect) rdata <= ram[bus.avm_address];
  assign bus.avm_readdata = rdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit toggle_mode = 0;
  bit pat [6] = '{1, 0, 0, 1, 0, 1};
  int pidx = 0;

  // Transfer log and issue model, updated once per clock edge.
  bit   run;
  int   t_start, tlen, issued, accepted, max_out, cs_err, hold_err;
  int   done_cnt, done_cyc, done_busy;
  int   cs_addr[$], cs_cyc[$], od[$], ol[$], oc[$];
  int   m_occ, m_pop;
  logic m_exp;
  bit   prev_stall;
  logic [7:0] prev_data;
  logic prev_last;

  always @(posedge clk) begin
    if (reset_n) begin
      m_pop = (bus.out_valid && bus.out_ready) ? 1 : 0;
      m_occ = issued - accepted;
      m_exp = run && (cyc > t_start) && (issued < tlen) && (m_occ - m_pop < 2);
      if (bus.avm_chipselect !== m_exp) cs_err++;
      if (m_occ > max_out) max_out = m_occ;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                         bus.out_last !== prev_last)) hold_err++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (bus.avm_chipselect) begin
        cs_addr.push_back(int'(bus.avm_address));
        cs_cyc.push_back(cyc);
        issued++;
      end
      if (m_pop == 1) begin
        od.push_back(int'(bus.out_data));
        ol.push_back(int'(bus.out_last));
        oc.push_back(cyc);
        accepted++;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = int'(busy);
      end
    end else begin
      prev_stall = 0;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_mode) begin
      bus.out_ready = pat[pidx];
      pidx = (pidx + 1) % 6;
    end
  endtask

  task automatic clear_log();
    run = 0; t_start = 0; tlen = 0; issued = 0; accepted = 0; max_out = 0;
    cs_err = 0; hold_err = 0; done_cnt = 0; done_cyc = 0; done_busy = 0;
    cs_addr.delete(); cs_cyc.delete(); od.delete(); ol.delete(); oc.delete();
  endtask

  task automatic start_xfer(input logic [14:0] b, input logic [15:0] l, output int t);
    clear_log();
    base_addr = b;
    length    = l;
    start     = 1'b1;
    run       = 1;
    t_start   = cyc;
    tlen      = int'(l);
    t         = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done_cnt == 0 && n < max) begin
      tick();
      n++;
    end
    check({tag, "_no_timeout"}, (done_cnt != 0), 1'b1);
    repeat (4) tick();
  endtask

  task automatic check_bytes(input string tag, input int n, input int first_val);
    check({tag, "_cs_count"}, cs_addr.size(), n);
    check({tag, "_out_count"}, od.size(), n);
    for (int i = 0; i < n && i < od.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), od[i], first_val + 'h11 * i);
      check($sformatf("%s_last%0d", tag, i), ol[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int t;
    int n;
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
    ram['h0100] = 8'h11; ram['h0101] = 8'h22; ram['h0102] = 8'h33; ram['h0103] = 8'h44;
    ram['h7FFE] = 8'hA1; ram['h7FFF] = 8'hB2; ram['h0000] = 8'hC3; ram['h0001] = 8'hD4;
    for (int i = 0; i < 8; i++) ram['h0200 + i] = 8'(8'h50 + i);
    clear_log();
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_cs", bus.avm_chipselect, 0);
    check("rst_addr", bus.avm_address, 0);
    check("tie_write", bus.avm_write, 0);
    check("tie_clken", bus.avm_clken, 1);
    reset_n = 1'b1;
    tick();

    // 1: basic 4-byte transfer, ready held high
    start_xfer(15'h0100, 16'd4, t);
    check("t1_busy_after_start", busy, 1);
    wait_done("t1", 40);
    check_bytes("t1", 4, 'h11);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), cs_addr[i], 'h100 + i);
      check($sformatf("t1_cs_cyc%0d", i), cs_cyc[i], t + 1 + i);
      check($sformatf("t1_out_cyc%0d", i), oc[i], t + 3 + i);
    end
    check("t1_done_cyc", done_cyc, t + 7);
    check("t1_done_busy", done_busy, 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_cs_model", cs_err, 0);

    // 2: same transfer under toggling backpressure
    pidx = 0;
    toggle_mode = 1;
    start_xfer(15'h0100, 16'd4, t);
    wait_done("t2", 80);
    toggle_mode = 0;
    bus.out_ready = 1'b1;
    check_bytes("t2", 4, 'h11);
    check("t2_hold", hold_err, 0);
    check("t2_max_outstanding_le2", (max_out <= 2), 1'b1);
    check("t2_cs_model", cs_err, 0);
    check("t2_done_cnt", done_cnt, 1);

    // 3: zero length
    start_xfer(15'h0100, 16'd0, t);
    wait_done("t3", 10);
    check("t3_done_cyc", done_cyc, t + 1);
    check("t3_cs_count", cs_addr.size(), 0);
    check("t3_out_count", od.size(), 0);
    check("t3_done_cnt", done_cnt, 1);

    // 4: address wrap
    start_xfer(15'h7FFE, 16'd4, t);
    wait_done("t4", 40);
    check_bytes("t4", 4, 'hA1 - 'h11 + 'h11);
    check("t4_addr0", cs_addr[0], 'h7FFE);
    check("t4_addr1", cs_addr[1], 'h7FFF);
    check("t4_addr2", cs_addr[2], 'h0000);
    check("t4_addr3", cs_addr[3], 'h0001);

    // 5: reset mid-transfer, then a fresh 1-byte transfer
    start_xfer(15'h0200, 16'd8, t);
    n = 0;
    while (accepted < 2 && n < 30) begin tick(); n++; end
    check("t5_two_bytes_seen", (accepted >= 2), 1'b1);
    check("t5_byte0", od[0], 'h50);
    check("t5_byte1", od[1], 'h51);
    reset_n = 1'b0;
    clear_log();
    tick();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_last", bus.out_last, 0);
    check("t5_rst_cs", bus.avm_chipselect, 0);
    check("t5_rst_addr", bus.avm_address, 0);
    check("t5_rst_data", bus.out_data, 0);
    reset_n = 1'b1;
    repeat (12) tick();
    check("t5_no_done", done_cnt, 0);
    check("t5_no_output", od.size(), 0);
    start_xfer(15'h0100, 16'd1, t);
    wait_done("t5b", 20);
    check_bytes("t5b", 1, 'h11);
    check("t5b_done_cnt", done_cnt, 1);

    // 6: start re-asserted mid-transfer is ignored
    start_xfer(15'h0100, 16'd4, t);
    tick();
    base_addr = 15'h7FFE;
    length    = 16'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6", 40);
    repeat (10) tick();
    check_bytes("t6", 4, 'h11);
    check("t6_addr0", cs_addr[0], 'h100);
    check("t6_addr3", cs_addr[3], 'h103);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_cs_model", cs_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
